// File: rtl/avalon_hex_ctrl_if.sv
// Register bus for avalon_hex_ctrl.
//   address   : register word address (0 VALUE, 1 CTRL, 2 INC, 3 STATUS)
//   write     : write strobe, single-cycle transfer, no wait states
//   writedata : write data
//   read      : read strobe
//   readdata  : registered read data, valid the cycle after read is sampled
interface avalon_hex_ctrl_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address,
    output write,
    output writedata,
    output read,
    input  readdata
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    input  read,
    output readdata
  );
endinterface

// File: rtl/avalon_hex_ctrl.sv
// Seven-segment display controller with a small register bus.
// Holds a NUM_DIGITS-nibble VALUE shown as hex digits, with enable,
// leading-zero blanking, per-digit blinking and a hex/BCD increment command.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : register bus (slave side), see avalon_hex_ctrl_if
//   hex_out  : active-low segments, digit i at [7i+6:7i], bit 6 = g .. bit 0 = a
module avalon_hex_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  avalon_hex_ctrl_if.slave        bus,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int VW    = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_INC    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [VW-1:0]           value_q;
  logic                    en_q;
  logic                    lzb_q;
  logic                    bcd_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    wrap_q;
  logic                    phase_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [31:0]             readdata_q;
  logic [7*NUM_DIGITS-1:0] hex_q;

  logic [VW-1:0]           inc_value;
  logic                    carry;
  logic [3:0]              digit;
  logic [31:0]             rd_mux;
  logic [NUM_DIGITS:1]     zero_from;
  logic [7*NUM_DIGITS-1:0] hex_d;

  // Only the low bits of writedata are meaningful; the rest are ignored.
  logic unused_wd;
  assign unused_wd = ^bus.writedata;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Next VALUE for an INC command. In BCD mode any digit >= 9 that receives
  // a carry rolls to 0 and propagates, so out-of-range digits behave like 9.
  always_comb begin
    inc_value = '0;
    carry     = 1'b1;
    digit     = '0;
    if (bcd_q) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        digit = value_q[4*i +: 4];
        if (carry) begin
          if (digit >= 4'd9) begin
            inc_value[4*i +: 4] = 4'd0;
          end else begin
            inc_value[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          inc_value[4*i +: 4] = digit;
        end
      end
    end else begin
      inc_value = value_q + VW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      en_q    <= 1'b0;
      lzb_q   <= 1'b0;
      bcd_q   <= 1'b0;
      blink_q <= '0;
      wrap_q  <= 1'b0;
    end else if (bus.write) begin
      case (bus.address)
        ADDR_VALUE: value_q <= bus.writedata[VW-1:0];
        ADDR_CTRL: begin
          en_q    <= bus.writedata[0];
          lzb_q   <= bus.writedata[1];
          bcd_q   <= bus.writedata[2];
          blink_q <= bus.writedata[8 +: NUM_DIGITS];
        end
        ADDR_INC: begin
          value_q <= inc_value;
          if (inc_value == '0) begin
            wrap_q <= 1'b1;
          end
        end
        default: begin
          if (bus.writedata[1]) begin
            wrap_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Free-running blink timebase, independent of EN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_VALUE: rd_mux[VW-1:0] = value_q;
      ADDR_CTRL: begin
        rd_mux[0]               = en_q;
        rd_mux[1]               = lzb_q;
        rd_mux[2]               = bcd_q;
        rd_mux[8 +: NUM_DIGITS] = blink_q;
      end
      ADDR_STATUS: rd_mux[1:0] = {wrap_q, phase_q};
      default: rd_mux = '0;
    endcase
  end

  // Mux samples pre-write state, so a simultaneous write is not visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (bus.read) begin
      readdata_q <= rd_mux;
    end
  end

  // zero_from[i]: digits i..NUM_DIGITS-1 are all zero (index NUM_DIGITS is
  // the empty set). Digit 0 is never leading-zero blanked.
  always_comb begin
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      zero_from[NUM_DIGITS-k] = zero_from[NUM_DIGITS-k+1] &
                                (value_q[4*(NUM_DIGITS-k) +: 4] == 4'd0);
    end
    hex_d = '1;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if (en_q && !(blink_q[i] && phase_q) && !(lzb_q && zero_from[i])) begin
        hex_d[7*i +: 7] = seg7(value_q[4*i +: 4]);
      end
    end
    if (en_q && !(blink_q[0] && phase_q)) begin
      hex_d[6:0] = seg7(value_q[3:0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_q <= '1;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign hex_out      = hex_q;

endmodule

// File: tb/tb_avalon_hex_ctrl.sv
// Self-checking bench for avalon_hex_ctrl (NUM_DIGITS=6, BLINK_DIV=4):
// directed scenarios plus randomized bus traffic against a behavioural model.
module tb_avalon_hex_ctrl;

  localparam int ND  = 6;
  localparam int DIV = 4;

  logic          clk;
  logic          reset_n;
  logic [41:0]   hex_out;

  avalon_hex_ctrl_if bus();

  avalon_hex_ctrl #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .hex_out (hex_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int unsigned m_value;
  int unsigned m_ctrl;
  int unsigned m_n;       // rising edges since reset release
  bit          m_wrap;
  logic [41:0] exp_hex;
  logic [31:0] exp_rd;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int unsigned dtab [8] = '{0, 1, 8, 9, 9, 9, 10, 15};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned dig(input int unsigned v, input int unsigned i);
    return (v >> (4 * i)) & 32'hF;
  endfunction

  function automatic logic [41:0] model_hex(input int unsigned v, input int unsigned c,
                                            input int unsigned ph);
    logic [41:0] r;
    bit blank;
    for (int i = 0; i < ND; i++) begin
      blank = ((c & 1) == 0) ||
              ((((c >> (8 + i)) & 1) == 1) && ph == 1) ||
              (((c & 2) != 0) && i != 0 && (v >> (4 * i)) == 0);
      r[7*i +: 7] = blank ? 7'h7F : seg_tab[dig(v, i)];
    end
    return r;
  endfunction

  // Decimal increment: trailing digits >= 9 become 0, the first digit below
  // 9 is bumped; if every digit is >= 9 the result is zero.
  function automatic int unsigned bcd_inc(input int unsigned v);
    int unsigned j = 0;
    while (j < ND && dig(v, j) >= 9) j++;
    if (j == ND) return 0;
    return ((v >> (4 * j)) + 1) << (4 * j);
  endfunction

  function automatic int unsigned reg_of(input logic [1:0] a, input int unsigned ph);
    case (a)
      2'd0: return m_value;
      2'd1: return m_ctrl;
      2'd2: return 0;
      default: return (m_wrap ? 2 : 0) | ph;
    endcase
  endfunction

  task automatic model_reset();
    m_value = 0;
    m_ctrl  = 0;
    m_n     = 0;
    m_wrap  = 0;
    exp_hex = '1;
    exp_rd  = '0;
  endtask

  task automatic model_step();
    int unsigned ph;
    logic [41:0] nh;
    ph = (m_n / DIV) % 2;
    nh = model_hex(m_value, m_ctrl, ph);
    if (bus.read) exp_rd = reg_of(bus.address, ph);
    if (bus.write) begin
      case (bus.address)
        2'd0: m_value = bus.writedata & 32'h00FF_FFFF;
        2'd1: m_ctrl  = bus.writedata & 32'h0000_3F07;
        2'd2: begin
          if ((m_ctrl & 4) != 0) m_value = bcd_inc(m_value);
          else m_value = (m_value + 1) & 32'h00FF_FFFF;
          if (m_value == 0) m_wrap = 1;
        end
        default: if (bus.writedata[1]) m_wrap = 0;
      endcase
    end
    m_n++;
    exp_hex = nh;
  endtask

  // One clock: advance model on the edge, compare outputs just after it.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("hex_out", 64'(hex_out), 64'(exp_hex));
    check("readdata", 64'(bus.readdata), 64'(exp_rd));
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    cycle();
    bus.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    bus.read    = 1'b1;
    cycle();
    d           = bus.readdata;
    bus.read    = 1'b0;
  endtask

  // Reset pulse entirely between two rising edges.
  task automatic pulse_reset();
    bus.write = 1'b0;
    bus.read  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_hex", 64'(hex_out), {22'd0, 42'h3FF_FFFF_FFFF});
    check("rst_rd", 64'(bus.readdata), 64'd0);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] d;
    int unsigned op, a, v;

    reset_n       = 1'b0;
    bus.address   = '0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    bus.read      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_hex", 64'(hex_out), {22'd0, 42'h3FF_FFFF_FFFF});
    check("init_rd", 64'(bus.readdata), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    bus_read(2'd3, d); check("rst_status", 64'(d), 64'd0);
    bus_read(2'd0, d); check("rst_value", 64'(d), 64'd0);
    bus_read(2'd1, d); check("rst_ctrl", 64'(d), 64'd0);

    // Plain hex display
    bus_write(2'd1, 32'h1);
    bus_write(2'd0, 32'h123456);
    cycle();
    check("hex_123456", 64'(hex_out),
          64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));

    // BCD carry chain with leading-zero blanking
    bus_write(2'd1, 32'h7);
    bus_write(2'd0, 32'h000999);
    bus_write(2'd2, 32'h0);
    cycle();
    check("hex_lzb", 64'(hex_out),
          64'({7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40}));
    bus_read(2'd0, d); check("bcd_1000", 64'(d), 64'h1000);

    // BCD all-9s wrap and WRAP clear
    bus_write(2'd1, 32'h5);
    bus_write(2'd0, 32'h999999);
    bus_write(2'd2, 32'hDEAD);
    bus_read(2'd0, d); check("bcd_wrap_val", 64'(d), 64'd0);
    bus_read(2'd3, d); check("wrap_set", 64'(d[1]), 64'd1);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, d); check("wrap_clr", 64'(d[1]), 64'd0);

    // Hex wrap, then out-of-range BCD digit
    bus_write(2'd1, 32'h1);
    bus_write(2'd0, 32'hFFFFFF);
    bus_write(2'd2, 32'h0);
    bus_read(2'd0, d); check("hex_wrap_val", 64'(d), 64'd0);
    bus_read(2'd3, d); check("hex_wrap_set", 64'(d[1]), 64'd1);
    bus_write(2'd1, 32'h5);
    bus_write(2'd0, 32'h00000A);
    bus_write(2'd2, 32'h0);
    bus_read(2'd0, d); check("bcd_A", 64'(d), 64'h10);

    // Read during write returns old contents; unused bits ignored
    bus.address = 2'd0; bus.writedata = 32'hFF654321; bus.write = 1'b1; bus.read = 1'b1;
    cycle();
    bus.write = 1'b0; bus.read = 1'b0;
    check("rd_before_wr", 64'(bus.readdata), 64'h10);
    bus_read(2'd0, d); check("value_mask", 64'(d), 64'h654321);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, d); check("ctrl_mask", 64'(d), 64'h3F07);

    // Blink digits 1..0
    bus_write(2'd1, 32'h0301);
    repeat (18) cycle();

    // Reset between edges mid-blink
    pulse_reset();
    bus_read(2'd3, d); check("post_rst_status", 64'(d), 64'd0);
    bus_read(2'd0, d); check("post_rst_value", 64'(d), 64'd0);
    bus_read(2'd1, d); check("post_rst_ctrl", 64'(d), 64'd0);
    bus_read(2'd2, d); check("post_rst_inc", 64'(d), 64'd0);

    // Randomized traffic
    for (int it = 0; it < 700; it++) begin
      op = $urandom_range(0, 11);
      a  = $urandom_range(0, 3);
      if (a == 0) begin
        v = 0;
        for (int k = 0; k < ND; k++) v |= dtab[$urandom_range(0, 7)] << (4 * k);
        if ($urandom_range(0, 3) == 0) v = $urandom;
      end else if (a == 1) begin
        v = $urandom;
        if ($urandom_range(0, 3) != 0) v |= 1;
      end else begin
        v = $urandom;
      end
      if (op <= 2) begin
        bus_write(2'(a), v);
      end else if (op <= 4) begin
        bus_write(2'd2, v);
      end else if (op <= 6) begin
        bus_read(2'(a), d);
      end else if (op == 7) begin
        bus.address = 2'(a); bus.writedata = v; bus.write = 1'b1; bus.read = 1'b1;
        cycle();
        bus.write = 1'b0; bus.read = 1'b0;
      end else if (op == 8 && $urandom_range(0, 40) == 0) begin
        pulse_reset();
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
